// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a parallel payload over valid/ready and
// shifts it out LSB first, one bit per baud_tick, with optional parity and 1-2 stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT_C = CW'(DATA_BITS);
    localparam logic STOP_LAST_C = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    // Odd parity is the complement of the payload XOR, even parity is the XOR itself.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
        if (PARITY == 2) begin
            parity_f = ^d;
        end else begin
            parity_f = ~^d;
        end
    endfunction

    state_t               state_r, state_s;
    logic                 tx_r, tx_s;
    logic                 ready_r, ready_s;
    logic                 done_r, done_s;
    logic                 busy_r, busy_s;
    logic [DATA_BITS-1:0] sh_r, sh_s;
    logic [CW-1:0]        bitcnt_r, bitcnt_s;
    logic                 par_r, par_s;
    logic                 stopcnt_r, stopcnt_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        tx_s      = tx_r;
        ready_s   = ready_r;
        done_s    = 1'b0;
        sh_s      = sh_r;
        bitcnt_s  = bitcnt_r;
        par_s     = par_r;
        stopcnt_s = stopcnt_r;
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                // ready_r gates the accept so a tick or valid during reset recovery is ignored
                if (in_valid && ready_r) begin
                    sh_s      = in_data;
                    par_s     = parity_f(in_data);
                    bitcnt_s  = '0;
                    stopcnt_s = 1'b0;
                    ready_s   = 1'b0;
                    state_s   = ST_SYNC;
                end else begin
                    ready_s = 1'b1;
                end
            end
            ST_SYNC: begin
                if (baud_tick) begin
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_s     = sh_r[0];
                    sh_s     = {1'b0, sh_r[DATA_BITS-1:1]};
                    bitcnt_s = CW'(1);
                    state_s  = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bitcnt_r < LAST_BIT_C) begin
                        tx_s     = sh_r[0];
                        sh_s     = {1'b0, sh_r[DATA_BITS-1:1]};
                        bitcnt_s = bitcnt_r + CW'(1);
                    end else if (PARITY != 0) begin
                        tx_s    = par_r;
                        state_s = ST_PARITY;
                    end else begin
                        tx_s      = 1'b1;
                        stopcnt_s = 1'b0;
                        state_s   = ST_STOP;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_s      = 1'b1;
                    stopcnt_s = 1'b0;
                    state_s   = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stopcnt_r == STOP_LAST_C) begin
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        stopcnt_s = stopcnt_r + 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                tx_s    = 1'b1;
                ready_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tx_r      <= 1'b1;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            sh_r      <= '0;
            bitcnt_r  <= '0;
            par_r     <= 1'b0;
            stopcnt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            tx_r      <= tx_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            sh_r      <= sh_s;
            bitcnt_r  <= bitcnt_s;
            par_r     <= par_s;
            stopcnt_r <= stopcnt_s;
        end
    end

    assign tx       = tx_r;
    assign in_ready = ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
